// File: rtl/comm_uart_ctrl_if.sv
// Byte channel between the UART engines and the command controller.
// The master presents a byte on data together with a single-cycle valid strobe.
interface comm_uart_ctrl_if;
  logic [7:0] data;
  logic       valid;

  modport master (output data, output valid);
  modport slave  (input  data, input  valid);
endinterface

// File: rtl/comm_uart_ctrl.sv
// UART command controller: receives command bytes, answers read requests and
// holds the 16-bit pin-enable mask for the console mux.

// 8N1 receiver; presents each byte with a one-cycle valid at the stop-bit centre.
module comm_uart_rx #(
  parameter int unsigned CLK_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  comm_uart_ctrl_if.master out_ch
);
  localparam int unsigned   CW   = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t     state, state_nx;
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          line;
  logic          tick;

  assign line = sync[1];
  assign tick = (cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= R_IDLE;
    else     state <= state_nx;
  end

  // Next state; a start bit that is high again at half a bit is a glitch
  always_comb begin
    state_nx = state;
    case (state)
      R_IDLE:  if (!line) state_nx = R_START;
      R_START: if (tick) state_nx = line ? R_IDLE : R_DATA;
      R_DATA:  if (tick && bit_idx == 3'd7) state_nx = R_STOP;
      R_STOP:  if (tick) state_nx = R_IDLE;
      default: state_nx = R_IDLE;
    endcase
  end

  // Line synchroniser, bit timing, shift register and byte output
  always_ff @(posedge clk) begin
    if (rst) begin
      sync         <= 2'b11;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      out_ch.data  <= '0;
      out_ch.valid <= 1'b0;
    end else begin
      sync         <= {sync[0], rx};
      out_ch.valid <= 1'b0;
      if (state == R_IDLE) begin
        cnt     <= HALF;
        bit_idx <= '0;
      end else if (tick) begin
        cnt <= FULL;
        if (state == R_DATA) begin
          shreg   <= {line, shreg[7:1]};
          bit_idx <= 3'(bit_idx + 3'd1);
        end
        if (state == R_STOP && line) begin
          out_ch.data  <= shreg;
          out_ch.valid <= 1'b1;
        end
      end else begin
        cnt <= CW'(cnt - 1'b1);
      end
    end
  end
endmodule

// 8N1 transmitter; done pulses for one cycle at the end of the stop bit.
module comm_uart_tx #(
  parameter int unsigned CLK_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  comm_uart_ctrl_if.slave in_ch,
  output logic            tx,
  output logic            done
);
  localparam int unsigned   CW   = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);

  typedef enum logic {T_IDLE, T_BUSY} tx_state_t;

  tx_state_t     state, state_nx;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    frame;
  logic          tick;

  assign tick = (cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= T_IDLE;
    else     state <= state_nx;
  end

  // Next state; start requests while busy are ignored
  always_comb begin
    state_nx = state;
    case (state)
      T_IDLE:  if (in_ch.valid) state_nx = T_BUSY;
      T_BUSY:  if (tick && bit_idx == 4'd9) state_nx = T_IDLE;
      default: state_nx = T_IDLE;
    endcase
  end

  // Serial line, bit timing and done pulse; frame holds data bits then stop
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 1'b1;
      done    <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      frame   <= '0;
    end else begin
      done <= 1'b0;
      if (state == T_IDLE) begin
        cnt     <= FULL;
        bit_idx <= '0;
        if (in_ch.valid) begin
          tx    <= 1'b0;
          frame <= {1'b1, in_ch.data};
        end else begin
          tx <= 1'b1;
        end
      end else if (tick) begin
        cnt     <= FULL;
        bit_idx <= 4'(bit_idx + 4'd1);
        if (bit_idx == 4'd9) begin
          done <= 1'b1;
        end else begin
          tx    <= frame[0];
          frame <= {1'b1, frame[8:1]};
        end
      end else begin
        cnt <= CW'(cnt - 1'b1);
      end
    end
  end
endmodule

// Command decoder, enable-mask register and response sequencer.
module comm_uart_ctrl #(
  parameter int unsigned CLK_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        serial_rx,
  output logic        serial_tx,
  output logic [15:0] enabled_out
);
  localparam logic [7:0]  COMM_READ_PIN_MAP      = 8'h01;
  localparam logic [7:0]  COMM_READ_ENABLE_MASK  = 8'h02;
  localparam logic [7:0]  COMM_WRITE_ENABLE_MASK = 8'h03;
  localparam logic [31:0] PIN_MAP                = 32'hAABBCCDD;
  localparam logic [15:0] MASK_RESET             = 16'hAA55;

  typedef enum logic [1:0] {C_IDLE, C_PAYLOAD, C_SEND, C_WAIT} ctrl_state_t;

  ctrl_state_t state, state_nx;
  logic [31:0] resp;
  logic [2:0]  resp_len;
  logic [2:0]  idx;
  logic        pay_idx;
  logic [7:0]  shadow;
  logic        tx_done;

  comm_uart_ctrl_if rx_ch ();
  comm_uart_ctrl_if tx_ch ();

  comm_uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
    .clk    (clk),
    .rst    (rst),
    .rx     (serial_rx),
    .out_ch (rx_ch)
  );

  comm_uart_tx #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .in_ch (tx_ch),
    .tx    (serial_tx),
    .done  (tx_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= C_IDLE;
    else     state <= state_nx;
  end

  // Next state; unknown codes and bytes arriving mid-response are dropped
  always_comb begin
    state_nx = state;
    case (state)
      C_IDLE: if (rx_ch.valid) begin
        if (rx_ch.data == COMM_READ_PIN_MAP || rx_ch.data == COMM_READ_ENABLE_MASK)
          state_nx = C_SEND;
        else if (rx_ch.data == COMM_WRITE_ENABLE_MASK)
          state_nx = C_PAYLOAD;
      end
      C_PAYLOAD: if (rx_ch.valid && pay_idx) state_nx = C_SEND;
      C_SEND:    state_nx = C_WAIT;
      C_WAIT:    if (tx_done) state_nx = (3'(idx + 3'd1) < resp_len) ? C_SEND : C_IDLE;
      default:   state_nx = C_IDLE;
    endcase
  end

  // TX start strobe and current response byte, LSB first
  always_comb begin
    tx_ch.valid = 1'b0;
    tx_ch.data  = resp[{idx[1:0], 3'b000} +: 8];
    if (state == C_SEND) tx_ch.valid = 1'b1;
  end

  // Response word, byte index, payload shadow and the enable mask
  always_ff @(posedge clk) begin
    if (rst) begin
      enabled_out <= MASK_RESET;
      resp        <= '0;
      resp_len    <= '0;
      idx         <= '0;
      pay_idx     <= 1'b0;
      shadow      <= '0;
    end else begin
      case (state)
        C_IDLE: if (rx_ch.valid) begin
          idx     <= '0;
          pay_idx <= 1'b0;
          if (rx_ch.data == COMM_READ_PIN_MAP) begin
            resp     <= PIN_MAP;
            resp_len <= 3'd4;
          end else if (rx_ch.data == COMM_READ_ENABLE_MASK) begin
            resp     <= {16'h0000, enabled_out};
            resp_len <= 3'd2;
          end
        end
        C_PAYLOAD: if (rx_ch.valid) begin
          if (!pay_idx) begin
            shadow  <= rx_ch.data;
            pay_idx <= 1'b1;
          end else begin
            enabled_out <= {rx_ch.data, shadow};
            resp        <= {16'h0000, rx_ch.data, shadow};
            resp_len    <= 3'd2;
            pay_idx     <= 1'b0;
          end
        end
        C_WAIT: if (tx_done) idx <= 3'(idx + 3'd1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_comm_uart_ctrl.sv
// Bench for comm_uart_ctrl: drives host bytes on serial_rx, decodes serial_tx,
// and compares against a byte-stream command model.
`timescale 1ns/1ps
module tb_comm_uart_ctrl;
  localparam int unsigned CPB     = 16;
  localparam logic [31:0] PIN_MAP = 32'hAABBCCDD;

  logic        clk = 1'b0;
  logic        rst;
  logic        serial_rx;
  logic        serial_tx;
  logic [15:0] enabled_out;

  int errors = 0;
  int checks = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] m_mask;
  int          m_mode;
  logic [7:0]  m_lo;

  comm_uart_ctrl_if mon ();

  comm_uart_ctrl #(.CLK_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .serial_rx   (serial_rx),
    .serial_tx   (serial_tx),
    .enabled_out (enabled_out)
  );

  always #5 clk = ~clk;

  // Decode bytes from serial_tx, sampling mid-bit
  initial begin
    mon.valid = 1'b0;
    mon.data  = 8'h00;
    forever begin
      logic [7:0] b;
      @(negedge serial_tx);
      repeat (CPB / 2) @(posedge clk);
      #1;
      if (serial_tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #1;
          b[i] = serial_tx;
        end
        repeat (CPB) @(posedge clk);
        #1;
        if (serial_tx == 1'b1) begin
          mon.data  = b;
          mon.valid = 1'b1;
          @(posedge clk);
          #1;
          mon.valid = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) if (mon.valid) rx_q.push_back(mon.data);

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Host-side command semantics at byte-stream level
  task automatic model_byte(input logic [7:0] b);
    if (m_mode == 0) begin
      if (b == 8'h01) begin
        for (int i = 0; i < 4; i++) exp_q.push_back(8'((PIN_MAP >> (8 * i)) & 32'hFF));
      end else if (b == 8'h02) begin
        exp_q.push_back(8'(m_mask % 256));
        exp_q.push_back(8'(m_mask / 256));
      end else if (b == 8'h03) begin
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      m_lo   = b;
      m_mode = 2;
    end else begin
      m_mask = 16'(b * 256 + m_lo);
      m_mode = 0;
      exp_q.push_back(m_lo);
      exp_q.push_back(b);
    end
  endtask

  task automatic model_reset();
    m_mask = 16'hAA55;
    m_mode = 0;
    m_lo   = 8'h00;
    exp_q.delete();
  endtask

  // One 8N1 frame; with jit each bit edge moves by -1..+1 cycles around its ideal time
  task automatic send_byte(input logic [7:0] b, input bit jit);
    logic [9:0] fr;
    int j_prev, j_next, len;
    fr = {1'b1, b, 1'b0};
    j_prev = 0;
    for (int k = 0; k < 10; k++) begin
      j_next = (jit && k < 9) ? int'($urandom_range(2)) - 1 : 0;
      serial_rx = fr[k];
      len = CPB + j_next - j_prev;
      step(len);
      j_prev = j_next;
    end
    model_byte(b);
  endtask

  // Bounded wait for the expected number of response bytes, then a quiet window
  task automatic wait_resp();
    int budget;
    budget = 3000;
    while (rx_q.size() < exp_q.size() && budget > 0) begin
      step(1);
      budget--;
    end
    step(12 * CPB);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    model_reset();
    step(1);
    rx_q.delete();
  endtask

  task automatic test_reset();
    serial_rx = 1'b1;
    do_reset();
    checks++;
    if (enabled_out !== 16'hAA55) begin
      $display("FAIL reset_mask got=%h required=%h", enabled_out, 16'hAA55); errors++;
    end
    checks++;
    if (serial_tx !== 1'b1) begin
      $display("FAIL reset_tx got=%b required=1", serial_tx); errors++;
    end
  endtask

  task automatic test_read_pin_map();
    for (int r = 0; r < 2; r++) begin
      send_byte(8'h01, 1'b0);
      wait_resp();
      checks++;
      if (rx_q.size() != 4 || exp_q.size() != 4) begin
        $display("FAIL pin_map_len rep=%0d got=%0d required=4", r, rx_q.size()); errors++;
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        logic [7:0] g;
        g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
        checks++;
        if (g !== exp_q[i]) begin
          $display("FAIL pin_map_byte%0d rep=%0d got=%h required=%h", i, r, g, exp_q[i]); errors++;
        end
      end
      rx_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_read_mask();
    send_byte(8'h02, 1'b0);
    wait_resp();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      $display("FAIL read_mask_len got=%0d required=%0d", rx_q.size(), exp_q.size()); errors++;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] g;
      g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++;
      if (g !== exp_q[i]) begin
        $display("FAIL read_mask_byte%0d got=%h required=%h", i, g, exp_q[i]); errors++;
      end
    end
    checks++;
    if (enabled_out !== m_mask) begin
      $display("FAIL read_mask_side_effect got=%h required=%h", enabled_out, m_mask); errors++;
    end
    rx_q.delete(); exp_q.delete();
  endtask

  // Write then read back; payload bytes arrive back-to-back with the command
  task automatic test_write(input logic [7:0] lo, input logic [7:0] hi);
    send_byte(8'h03, 1'b0);
    send_byte(lo, 1'b0);
    send_byte(hi, 1'b0);
    wait_resp();
    checks++;
    if (enabled_out !== m_mask) begin
      $display("FAIL write_mask got=%h required=%h", enabled_out, m_mask); errors++;
    end
    send_byte(8'h02, 1'b0);
    wait_resp();
    checks++;
    if (rx_q.size() != exp_q.size() || exp_q.size() != 4) begin
      $display("FAIL write_len got=%0d required=%0d", rx_q.size(), exp_q.size()); errors++;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] g;
      g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++;
      if (g !== exp_q[i]) begin
        $display("FAIL write_byte%0d got=%h required=%h", i, g, exp_q[i]); errors++;
      end
    end
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic test_unknown();
    send_byte(8'h7F, 1'b0);
    wait_resp();
    checks++;
    if (rx_q.size() != 0) begin
      $display("FAIL unknown_silent got=%0d bytes required=0", rx_q.size()); errors++;
    end
    rx_q.delete();
    send_byte(8'h02, 1'b0);
    wait_resp();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      $display("FAIL unknown_then_read_len got=%0d required=%0d", rx_q.size(), exp_q.size()); errors++;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] g;
      g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++;
      if (g !== exp_q[i]) begin
        $display("FAIL unknown_then_read_byte%0d got=%h required=%h", i, g, exp_q[i]); errors++;
      end
    end
    rx_q.delete(); exp_q.delete();
  endtask

  // Reset between payload bytes discards the partial write
  task automatic test_reset_payload();
    int lows;
    send_byte(8'h03, 1'b0);
    send_byte(8'h34, 1'b0);
    do_reset();
    lows = 0;
    for (int c = 0; c < 12 * CPB; c++) begin
      if (serial_tx !== 1'b1) lows++;
      step(1);
    end
    checks++;
    if (lows != 0) begin
      $display("FAIL reset_payload_tx_idle got=%0d low cycles required=0", lows); errors++;
    end
    checks++;
    if (enabled_out !== 16'hAA55) begin
      $display("FAIL reset_payload_mask got=%h required=%h", enabled_out, 16'hAA55); errors++;
    end
    send_byte(8'h02, 1'b0);
    wait_resp();
    checks++;
    if (rx_q.size() != 2) begin
      $display("FAIL reset_payload_read_len got=%0d required=2", rx_q.size()); errors++;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] g;
      g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++;
      if (g !== exp_q[i]) begin
        $display("FAIL reset_payload_read_byte%0d got=%h required=%h", i, g, exp_q[i]); errors++;
      end
    end
    rx_q.delete(); exp_q.delete();
  endtask

  // Reset during a response frame forces the line high on the next cycle
  task automatic test_reset_tx();
    int budget;
    send_byte(8'h01, 1'b0);
    budget = 200;
    while (serial_tx !== 1'b0 && budget > 0) begin
      step(1);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      $display("FAIL reset_tx_start timeout got=no start bit required=start bit"); errors++;
    end
    step(3 * CPB);
    rst = 1'b1;
    step(1);
    checks++;
    if (serial_tx !== 1'b1) begin
      $display("FAIL reset_tx_abort got=%b required=1", serial_tx); errors++;
    end
    step(1);
    rst = 1'b0;
    model_reset();
    step(12 * CPB);
    rx_q.delete();
  endtask

  // Random command mix with bit-edge jitter
  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      int sel;
      sel = int'($urandom_range(3));
      case (sel)
        0: send_byte(8'h01, 1'b1);
        1: send_byte(8'h02, 1'b1);
        2: begin
          send_byte(8'h03, 1'b1);
          send_byte(8'($urandom_range(255)), 1'b1);
          send_byte(8'($urandom_range(255)), 1'b1);
        end
        default: begin
          send_byte(8'(4 + $urandom_range(250)), 1'b1);
          send_byte(8'h02, 1'b1);
        end
      endcase
      wait_resp();
      checks++;
      if (rx_q.size() != exp_q.size()) begin
        $display("FAIL random%0d_len sel=%0d got=%0d required=%0d", n, sel, rx_q.size(), exp_q.size()); errors++;
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        logic [7:0] g;
        g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
        checks++;
        if (g !== exp_q[i]) begin
          $display("FAIL random%0d_byte%0d got=%h required=%h", n, i, g, exp_q[i]); errors++;
        end
      end
      checks++;
      if (enabled_out !== m_mask) begin
        $display("FAIL random%0d_mask got=%h required=%h", n, enabled_out, m_mask); errors++;
      end
      rx_q.delete(); exp_q.delete();
    end
  endtask

  initial begin
    rst       = 1'b1;
    serial_rx = 1'b1;
    model_reset();
    step(2);
    test_reset();
    test_read_pin_map();
    do_reset();
    test_read_mask();
    test_write(8'hCD, 8'hAB);
    test_write(8'hAA, 8'hAA);
    test_unknown();
    test_reset_payload();
    test_reset_tx();
    test_read_mask();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
